sdcard_cmd_seq: RTL and testbench
=================================

SDCARD_CMD_SEQ -- requirements
Module: sdcard_cmd_seq

Interface
REQ-001 SHALL have parameter NCR_MAX, default 8: max R1 poll bytes before timeout (1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-004 SHALL have port cmd_start  input  1  one-cycle request to issue a command.
REQ-005 SHALL have port cmd_index  input  6  SD command index; sampled on accepted cmd_start.
REQ-006 SHALL have port cmd_arg  input  32  command argument; sampled on accepted cmd_start.
REQ-007 SHALL have port resp_len  input  3  extra response bytes after R1 (0..4; 5..7 treated as 4); sampled on accepted cmd_start.
REQ-008 SHALL have port cmd_busy  output  1  high while a command is in progress.
REQ-009 SHALL have port cmd_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port cmd_timeout  output  1  status of last command; no R1 within NCR_MAX polls.
REQ-011 SHALL have port resp_r1  output  8  R1 byte of last command.
REQ-012 SHALL have port resp_data  output  32  extra response bytes, right-justified, first byte most significant.
REQ-013 SHALL have port spi_data_in  output  8  byte to transmit, to the SPI byte engine.
REQ-014 SHALL have port spi_bits  output  5  bit count to the engine, constant 7 (full byte).
REQ-015 SHALL have port spi_start  output  1  one-cycle transfer start to the engine.
REQ-016 SHALL have port spi_finished  input  1  one-cycle transfer-complete pulse from the engine.
REQ-017 SHALL have port spi_data_out  input  8  received byte; valid in the spi_finished cycle.

Function
REQ-018 SHALL implement states IDLE, PRE, SEND, POLL, DATA, DONE.
REQ-019 SHALL accept cmd_start only in IDLE; cmd_start in any other state is ignored with no side effect.
REQ-020 On accept, SHALL latch inputs, clear cmd_timeout, resp_r1=8'hFF, resp_data=0, enter PRE, and assert cmd_busy from the next cycle.
REQ-021 Each byte transfer: spi_start high exactly one cycle with spi_data_in stable from that cycle until spi_finished; the next spi_start is in the cycle after spi_finished; never more than one transfer outstanding.
REQ-022 First spi_start SHALL occur the cycle after acceptance.
REQ-023 PRE: send one 8'hFF byte, then SEND.
REQ-024 SEND: send 6 bytes in order {2'b01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1'b1}.
REQ-025 crc7 SHALL be polynomial x^7+x^3+1, initial value 0, computed MSB-first over the first 5 frame bytes.
REQ-026 POLL: send 8'hFF bytes; the first received byte with bit7=0 is stored in resp_r1.
REQ-027 After NCR_MAX poll bytes with bit7=1, SHALL set cmd_timeout=1, keep resp_r1=8'hFF, and go to DONE.
REQ-028 After R1: if resp_len=0 or any of R1[6:1] is set, go to DONE; otherwise go to DATA.
REQ-029 DATA: send resp_len 8'hFF bytes; each received byte is shifted in as resp_data={resp_data[23:0],byte}.
REQ-030 DONE SHALL last one cycle: cmd_done=1, cmd_busy=1; the next cycle is IDLE with cmd_busy=0.
REQ-031 A cmd_start in the DONE cycle SHALL be ignored; the earliest new accept is the first IDLE cycle.
REQ-032 resp_r1, resp_data and cmd_timeout SHALL hold their values from DONE until the next accepted cmd_start.
REQ-033 A spi_finished arriving in IDLE or DONE SHALL be ignored.
REQ-034 Poll counter SHALL be 8 bits and SHALL not wrap; the NCR_MAX compare is exact.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-transfer.
REQ-036 Reset values: cmd_busy=0, cmd_done=0, cmd_timeout=0, spi_start=0, resp_r1=8'hFF, resp_data=0, spi_data_in=8'hFF, spi_bits=7.
REQ-037 After reset release, SHALL issue no spi_start until a new accepted cmd_start.

Verification
REQ-038 CMD0: cmd_start, index=0, arg=0, resp_len=0, engine model returns 0xFF, 0xFF, 0x01 on polls -> TX bytes FF 40 00 00 00 00 95, then FF FF FF; resp_r1=0x01; cmd_timeout=0; one cmd_done pulse.
REQ-039 CMD8: index=8, arg=0x000001AA, resp_len=4, R1=0x01, data bytes 00 00 01 AA -> CRC byte 0x87; resp_data=0x000001AA.
REQ-040 Timeout: NCR_MAX=8, model always returns 0xFF -> exactly 8 poll bytes; cmd_timeout=1; resp_r1=0xFF; cmd_done.
REQ-041 Error R1: resp_len=4, R1=0x05 -> no DATA bytes sent; resp_data=0; cmd_done the cycle after R1's spi_finished.
REQ-042 Busy rejection: cmd_start pulsed during SEND and in the DONE cycle -> ignored; byte sequence and latched arg unchanged.
REQ-043 Reset mid-SEND: rst_n=0 while the 3rd byte is in flight -> next cycle cmd_busy=0 and all outputs at reset values; a late spi_finished causes no spi_start.

Source files
------------

// File: rtl/sdcard_cmd_seq_if.sv
// Command/response and SPI byte-engine signals of the SD card command sequencer.
// The slave modport is the sequencer; the master modport is its environment
// (command issuer plus the SPI byte engine).
interface sdcard_cmd_seq_if;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [2:0]  resp_len;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_timeout;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic [7:0]  spi_data_in;
    logic [4:0]  spi_bits;
    logic        spi_start;
    logic        spi_finished;
    logic [7:0]  spi_data_out;

    modport slave (
        input  cmd_start,
        input  cmd_index,
        input  cmd_arg,
        input  resp_len,
        output cmd_busy,
        output cmd_done,
        output cmd_timeout,
        output resp_r1,
        output resp_data,
        output spi_data_in,
        output spi_bits,
        output spi_start,
        input  spi_finished,
        input  spi_data_out
    );

    modport master (
        output cmd_start,
        output cmd_index,
        output cmd_arg,
        output resp_len,
        input  cmd_busy,
        input  cmd_done,
        input  cmd_timeout,
        input  resp_r1,
        input  resp_data,
        input  spi_data_in,
        input  spi_bits,
        input  spi_start,
        output spi_finished,
        output spi_data_out
    );
endinterface

// File: rtl/sdcard_cmd_seq.sv
// SD card SPI-mode command sequencer: sends a 0xFF preamble byte, the 6-byte
// command frame with CRC7, polls for R1 and collects up to 4 extra response
// bytes, driving a one-byte-at-a-time SPI engine.
module sdcard_cmd_seq #(
    parameter int unsigned NCR_MAX = 8
) (
    input logic             clk,
    input logic             rst_n,
    sdcard_cmd_seq_if.slave bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PRE  = 3'd1;
    localparam logic [2:0] SEND = 3'd2;
    localparam logic [2:0] POLL = 3'd3;
    localparam logic [2:0] DATA = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [7:0] NcrMax = 8'(NCR_MAX);

    // CRC7 (x^7 + x^3 + 1), zero initial value, MSB-first over 40 frame bits
    function automatic logic [6:0] crc7_calc(input logic [39:0] bits);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = bits[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  poll_q, poll_d;
    logic        start_q, start_d;
    logic [7:0]  tx_q, tx_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] data_q, data_d;

    logic [6:0]  crc7;
    logic [2:0]  frame_sel;
    logic [7:0]  frame_byte;
    logic [7:0]  poll_inc;
    logic [2:0]  len_clamped;

    // CRC over the latched command; stable for the whole command
    always_comb begin
        crc7 = crc7_calc({2'b01, idx_q, arg_q});
    end

    // Frame byte for the next SEND transfer (byte 0 when leaving PRE)
    always_comb begin
        frame_sel  = (state_q == PRE) ? 3'd0 : cnt_q + 3'd1;
        frame_byte = 8'hFF;
        case (frame_sel)
            3'd0:    frame_byte = {2'b01, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            3'd5:    frame_byte = {crc7, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    // Poll counter saturates rather than wrapping; lengths above 4 mean 4
    always_comb begin
        poll_inc    = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;
        len_clamped = (bus.resp_len > 3'd4) ? 3'd4 : bus.resp_len;
    end

    // Next-state logic: one transfer outstanding at a time, each new byte
    // launched in the cycle after the previous spi_finished
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        start_d   = 1'b0;
        tx_d      = tx_q;
        timeout_d = timeout_q;
        r1_d      = r1_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_start) begin
                    idx_d     = bus.cmd_index;
                    arg_d     = bus.cmd_arg;
                    len_d     = len_clamped;
                    timeout_d = 1'b0;
                    r1_d      = 8'hFF;
                    data_d    = '0;
                    cnt_d     = '0;
                    poll_d    = '0;
                    start_d   = 1'b1;
                    tx_d      = 8'hFF;
                    state_d   = PRE;
                end
            end
            PRE: begin
                if (bus.spi_finished) begin
                    cnt_d   = '0;
                    start_d = 1'b1;
                    tx_d    = frame_byte;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.spi_finished) begin
                    start_d = 1'b1;
                    if (cnt_q == 3'd5) begin
                        poll_d  = '0;
                        tx_d    = 8'hFF;
                        state_d = POLL;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        tx_d  = frame_byte;
                    end
                end
            end
            POLL: begin
                if (bus.spi_finished) begin
                    poll_d = poll_inc;
                    if (!bus.spi_data_out[7]) begin
                        r1_d = bus.spi_data_out;
                        // Error bits in R1 suppress the trailing data bytes
                        if (len_q == 3'd0 || |bus.spi_data_out[6:1]) begin
                            state_d = DONE;
                        end else begin
                            cnt_d   = '0;
                            start_d = 1'b1;
                            tx_d    = 8'hFF;
                            state_d = DATA;
                        end
                    end else if (poll_inc == NcrMax) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        start_d = 1'b1;
                        tx_d    = 8'hFF;
                    end
                end
            end
            DATA: begin
                if (bus.spi_finished) begin
                    data_d = {data_q[23:0], bus.spi_data_out};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == len_q) begin
                        state_d = DONE;
                    end else begin
                        start_d = 1'b1;
                        tx_d    = 8'hFF;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            arg_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            poll_q    <= '0;
            start_q   <= 1'b0;
            tx_q      <= 8'hFF;
            timeout_q <= 1'b0;
            r1_q      <= 8'hFF;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            timeout_q <= timeout_d;
            r1_q      <= r1_d;
            data_q    <= data_d;
        end
    end

    // Output drive
    always_comb begin
        bus.cmd_busy    = (state_q != IDLE);
        bus.cmd_done    = (state_q == DONE);
        bus.cmd_timeout = timeout_q;
        bus.resp_r1     = r1_q;
        bus.resp_data   = data_q;
        bus.spi_data_in = tx_q;
        bus.spi_bits    = 5'd7;
        bus.spi_start   = start_q;
    end

endmodule

// File: tb/tb_sdcard_cmd_seq.sv
// Directed bench for sdcard_cmd_seq with a behavioural SPI byte engine.
module tb_sdcard_cmd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdcard_cmd_seq_if bus ();

    sdcard_cmd_seq #(
        .NCR_MAX(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_log[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    int fin_cyc = 0;
    int done_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: one-cycle latency, replies 0xFF to preamble/frame bytes and
    // then pops scripted replies (0xFF once the script is exhausted)
    initial begin
        logic [7:0] last;
        bus.spi_finished = 1'b0;
        bus.spi_data_out = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            while (bus.spi_start) begin
                last = bus.spi_data_in;
                tx_log.push_back(last);
                @(posedge clk);
                #1;
                if (bus.cmd_busy) begin
                    chk("spi_hold", {bus.spi_start, bus.spi_data_in}, {1'b0, last});
                end
                bus.spi_finished = 1'b1;
                if (tx_log.size() > 7 && rx_q.size() > 0) bus.spi_data_out = rx_q.pop_front();
                else bus.spi_data_out = 8'hFF;
                @(posedge clk);
                #1;
                bus.spi_finished = 1'b0;
            end
        end
    end

    // Event monitor sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.spi_finished) fin_cyc = cyc;
            if (bus.cmd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.spi_start) start_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [2:0] len);
        tx_log.delete();
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_len  = len;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
    endtask

    // Returns at the DONE cycle (just after the falling edge) or on timeout
    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt - d0, 1);
        chk({tag, "_busy_in_done"}, bus.cmd_busy, 1'b1);
    endtask

    task automatic check_tx(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_tx_count"}, tx_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < tx_log.size(); i++) begin
            chk($sformatf("%s_tx%0d", tag, i), tx_log[i], exp[i]);
        end
    endtask

    initial begin
        int d0;
        int s0;
        int n;
        bus.cmd_start = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg   = '0;
        bus.resp_len  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Reset values
        chk("rst_busy", bus.cmd_busy, 1'b0);
        chk("rst_done", bus.cmd_done, 1'b0);
        chk("rst_timeout", bus.cmd_timeout, 1'b0);
        chk("rst_spi_start", bus.spi_start, 1'b0);
        chk("rst_r1", bus.resp_r1, 8'hFF);
        chk("rst_data", bus.resp_data, 32'h0);
        chk("rst_data_in", bus.spi_data_in, 8'hFF);
        chk("rst_bits", bus.spi_bits, 5'd7);
        repeat (4) @(negedge clk);
        chk("rst_no_start", start_cnt, 0);

        // CMD0
        rx_q = '{8'hFF, 8'hFF, 8'h01};
        d0 = done_cnt;
        start_cmd(6'd0, 32'h0, 3'd0);
        wait_done("cmd0");
        repeat (3) @(negedge clk);
        #1;
        exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        check_tx("cmd0", exp_q);
        chk("cmd0_r1", bus.resp_r1, 8'h01);
        chk("cmd0_timeout", bus.cmd_timeout, 1'b0);
        chk("cmd0_one_done", done_cnt - d0, 1);
        chk("cmd0_idle", bus.cmd_busy, 1'b0);

        // CMD8 with 4 data bytes
        rx_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        start_cmd(6'd8, 32'h0000_01AA, 3'd4);
        wait_done("cmd8");
        @(negedge clk);
        #1;
        exp_q = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_tx("cmd8", exp_q);
        chk("cmd8_r1", bus.resp_r1, 8'h01);
        chk("cmd8_data", bus.resp_data, 32'h0000_01AA);
        chk("cmd8_done_low", bus.cmd_done, 1'b0);

        // R1 with error bit: no data phase, resp_data cleared on accept
        rx_q = '{8'h05};
        start_cmd(6'd0, 32'h0, 3'd4);
        wait_done("err");
        chk("err_done_latency", done_cyc - fin_cyc, 1);
        @(negedge clk);
        #1;
        chk("err_tx_count", tx_log.size(), 8);
        chk("err_r1", bus.resp_r1, 8'h05);
        chk("err_data", bus.resp_data, 32'h0);

        // Timeout: 8 polls all 0xFF; resp_len=7 is irrelevant here
        rx_q.delete();
        start_cmd(6'd0, 32'h0, 3'd7);
        wait_done("tmo");
        repeat (3) @(negedge clk);
        #1;
        exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_tx("tmo", exp_q);
        chk("tmo_flag", bus.cmd_timeout, 1'b1);
        chk("tmo_r1", bus.resp_r1, 8'hFF);

        // Busy rejection: pulses during SEND and in the DONE cycle
        rx_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        d0 = done_cnt;
        start_cmd(6'd8, 32'h0000_01AA, 3'd6);
        n = 0;
        while (tx_log.size() < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("busy_reached_send", tx_log.size() >= 3, 1'b1);
        bus.cmd_start = 1'b1;
        bus.cmd_index = 6'd17;
        bus.cmd_arg   = 32'hDEAD_BEEF;
        bus.resp_len  = 3'd0;
        @(negedge clk);
        #1;
        bus.cmd_start = 1'b0;
        wait_done("busy");
        bus.cmd_start = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
        s0 = start_cnt;
        repeat (6) @(negedge clk);
        #1;
        exp_q = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_tx("busy", exp_q);
        chk("busy_data", bus.resp_data, 32'h0000_01AA);
        chk("busy_one_done", done_cnt - d0, 1);
        chk("busy_no_restart", start_cnt - s0, 0);
        chk("busy_idle", bus.cmd_busy, 1'b0);

        // Reset while the 3rd SEND byte is in flight
        rx_q.delete();
        start_cmd(6'd8, 32'h0000_01AA, 3'd4);
        n = 0;
        while (tx_log.size() < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_busy", bus.cmd_busy, 1'b0);
        chk("mrst_spi_start", bus.spi_start, 1'b0);
        chk("mrst_data_in", bus.spi_data_in, 8'hFF);
        chk("mrst_r1", bus.resp_r1, 8'hFF);
        chk("mrst_data", bus.resp_data, 32'h0);
        chk("mrst_timeout", bus.cmd_timeout, 1'b0);
        chk("mrst_done", bus.cmd_done, 1'b0);
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("mrst_no_start", start_cnt - s0, 0);
        chk("mrst_tx_count", tx_log.size(), 3);

        // Recovery after reset
        rx_q = '{8'h01};
        start_cmd(6'd0, 32'h0, 3'd0);
        wait_done("rec");
        @(negedge clk);
        #1;
        chk("rec_tx_count", tx_log.size(), 8);
        chk("rec_r1", bus.resp_r1, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
